// File: rtl/caliptra_prim_diff_pkg.sv
// Shared state and wire encodings for the differential pulse sender.
package caliptra_prim_diff_pkg;

    typedef enum logic [1:0] {
        DiffStIdle   = 2'b00,
        DiffStAssert = 2'b01,
        DiffStGap    = 2'b10,
        DiffStFrozen = 2'b11
    } diff_pulse_state_e;

    localparam logic DiffIdleP   = 1'b0;
    localparam logic DiffIdleN   = 1'b1;
    localparam logic DiffAssertP = 1'b1;
    localparam logic DiffAssertN = 1'b0;

    localparam int unsigned DiffTimerWidth = 4;

endpackage

// File: rtl/caliptra_prim_sat_counter.sv
// Saturating up/down event counter with a sticky overflow flag.
module caliptra_prim_sat_counter #(
    parameter int Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             overflow_o
);

    logic [Width-1:0] cnt_d, cnt_q;
    logic             overflow_d, overflow_q;

    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (inc_i && !dec_i) begin
            if (&cnt_q) begin
                overflow_d = 1'b1;
            end else begin
                cnt_d = cnt_q + Width'(1);
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/caliptra_prim_diff_pulse_sender.sv
// Turns single-cycle event requests into registered differential pulses.
//   state  | meaning
//   Idle   | p=0 n=1, waiting for a queued or fresh event
//   Assert | p=1 n=0, held for HoldCycles
//   Gap    | p=0 n=1, held for GapCycles before the next launch
//   Frozen | p=n=0, sigint test hook active, state/timer parked in shadow
module caliptra_prim_diff_pulse_sender
    import caliptra_prim_diff_pkg::*;
#(
    parameter int HoldCycles = 2,
    parameter int GapCycles  = 1,
    parameter int CntWidth   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                event_i,
    input  logic                force_sigint_i,
    output logic                diff_po,
    output logic                diff_no,
    output logic                busy_o,
    output logic [CntWidth-1:0] pending_o,
    output logic                overflow_o
);

    if (HoldCycles < 1 || HoldCycles > 15) begin : g_bad_hold
        $error("HoldCycles must be within 1..15");
    end
    if (GapCycles < 1 || GapCycles > 15) begin : g_bad_gap
        $error("GapCycles must be within 1..15");
    end
    if (CntWidth < 1) begin : g_bad_cnt
        $error("CntWidth must be at least 1");
    end

    localparam logic [DiffTimerWidth-1:0] HoldLoad = DiffTimerWidth'(HoldCycles - 1);
    localparam logic [DiffTimerWidth-1:0] GapLoad  = DiffTimerWidth'(GapCycles - 1);
    localparam logic [DiffTimerWidth-1:0] HoldCnt  = DiffTimerWidth'(HoldCycles);

    diff_pulse_state_e          state_d, state_q, adv_state;
    diff_pulse_state_e          shadow_state_d, shadow_state_q;
    logic [DiffTimerWidth-1:0]  timer_d, timer_q, adv_timer;
    logic [DiffTimerWidth-1:0]  shadow_timer_d, shadow_timer_q;
    logic [DiffTimerWidth-1:0]  hold_cnt_d, hold_cnt_q;
    logic                       diff_p_d, diff_p_q, diff_n_d, diff_n_q;
    logic [CntWidth-1:0]        pending;
    logic                       launch, queued_nz;

    assign queued_nz = (pending != '0);
    assign launch    = (state_q == DiffStIdle) && (queued_nz || event_i) && !force_sigint_i;

    // A fresh event launched with an empty queue is consumed on the spot.
    caliptra_prim_sat_counter #(
        .Width (CntWidth)
    ) u_pending (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (event_i && !(launch && !queued_nz)),
        .dec_i      (launch && queued_nz),
        .cnt_o      (pending),
        .overflow_o (overflow_o)
    );

    always_comb begin
        adv_state = state_q;
        adv_timer = timer_q;
        unique case (state_q)
            DiffStIdle: begin
                if (launch) begin
                    adv_state = DiffStAssert;
                    adv_timer = HoldLoad;
                end
            end
            DiffStAssert: begin
                if (timer_q == '0) begin
                    adv_state = DiffStGap;
                    adv_timer = GapLoad;
                end else begin
                    adv_timer = timer_q - DiffTimerWidth'(1);
                end
            end
            DiffStGap: begin
                if (timer_q == '0) begin
                    adv_state = DiffStIdle;
                end else begin
                    adv_timer = timer_q - DiffTimerWidth'(1);
                end
            end
            default: ;
        endcase
    end

    // Entering Frozen parks the step the force cycle would have taken, so the
    // pulse still spends exactly HoldCycles in Assert once released.
    always_comb begin
        state_d        = adv_state;
        timer_d        = adv_timer;
        shadow_state_d = shadow_state_q;
        shadow_timer_d = shadow_timer_q;
        if (state_q == DiffStFrozen) begin
            state_d = force_sigint_i ? DiffStFrozen : shadow_state_q;
            timer_d = force_sigint_i ? timer_q : shadow_timer_q;
        end else if (force_sigint_i) begin
            state_d        = DiffStFrozen;
            timer_d        = timer_q;
            shadow_state_d = adv_state;
            shadow_timer_d = adv_timer;
        end
    end

    always_comb begin
        diff_p_d = DiffIdleP;
        diff_n_d = DiffIdleN;
        unique case (state_d)
            DiffStAssert: begin
                diff_p_d = DiffAssertP;
                diff_n_d = DiffAssertN;
            end
            DiffStFrozen: begin
                diff_p_d = 1'b0;
                diff_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == DiffStIdle) begin
            hold_cnt_d = '0;
        end else if (state_q == DiffStAssert) begin
            hold_cnt_d = hold_cnt_q + DiffTimerWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= DiffStIdle;
            timer_q        <= '0;
            shadow_state_q <= DiffStIdle;
            shadow_timer_q <= '0;
            hold_cnt_q     <= '0;
            diff_p_q       <= DiffIdleP;
            diff_n_q       <= DiffIdleN;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            shadow_state_q <= shadow_state_d;
            shadow_timer_q <= shadow_timer_d;
            hold_cnt_q     <= hold_cnt_d;
            diff_p_q       <= diff_p_d;
            diff_n_q       <= diff_n_d;
        end
    end

    assign diff_po   = diff_p_q;
    assign diff_no   = diff_n_q;
    assign pending_o = pending;
    assign busy_o    = (state_q != DiffStIdle) || queued_nz;

    a_pair_differential: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != DiffStFrozen) |-> (diff_p_q != diff_n_q));

    a_pulse_width: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == DiffStGap) |-> (hold_cnt_q == HoldCnt));

endmodule

// File: tb/tb_caliptra_prim_diff_pulse_sender.sv
// Scoreboard bench: stimulus queues expected rise cycles, a monitor checks pulses.
module tb_caliptra_prim_diff_pulse_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       ev_a, force_a, ev_b, force_b;
    logic       p_a, n_a, busy_a, ovf_a;
    logic       p_b, n_b, busy_b, ovf_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int q_a[$];
    int q_b[$];
    logic prev_p[2];
    int   width[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    caliptra_prim_diff_pulse_sender dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .event_i        (ev_a),
        .force_sigint_i (force_a),
        .diff_po        (p_a),
        .diff_no        (n_a),
        .busy_o         (busy_a),
        .pending_o      (pend_a),
        .overflow_o     (ovf_a)
    );

    caliptra_prim_diff_pulse_sender #(
        .HoldCycles (6),
        .GapCycles  (1),
        .CntWidth   (2)
    ) dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .event_i        (ev_b),
        .force_sigint_i (force_b),
        .diff_po        (p_b),
        .diff_no        (n_b),
        .busy_o         (busy_b),
        .pending_o      (pend_b),
        .overflow_o     (ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives ev_a per cycle; nibble i / bit i hold pending and busy for cycle t+i+1.
    task automatic run_a(input string name, input logic [15:0] ev_pat, input int n,
                         input logic [63:0] pend_pat, input logic [15:0] busy_pat);
        for (int i = 0; i < n; i++) begin
            ev_a = ev_pat[i];
            tick(1);
            chk({name, "_pending"}, 32'(pend_a), 32'(pend_pat[i*4 +: 4]));
            chk({name, "_busy"}, 32'(busy_a), 32'(busy_pat[i]));
        end
        ev_a = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic  pk, nk;
            string sfx;
            pk  = (k == 0) ? p_a : p_b;
            nk  = (k == 0) ? n_a : n_b;
            sfx = (k == 0) ? "_a" : "_b";
            if (rst) begin
                prev_p[k] = 1'b0;
                width[k]  = 0;
            end else if (pk || nk) begin
                chk({"wire_pair", sfx}, 32'(nk), 32'(!pk));
                if (pk && !prev_p[k]) begin
                    chk({"rise_expected", sfx}, 32'((k == 0 ? q_a.size() : q_b.size()) != 0), 32'd1);
                    if (k == 0 && q_a.size() != 0) chk("rise_cycle_a", cyc, q_a.pop_front());
                    if (k == 1 && q_b.size() != 0) chk("rise_cycle_b", cyc, q_b.pop_front());
                    width[k] = 0;
                end
                if (pk) width[k]++;
                else if (prev_p[k]) chk({"pulse_width", sfx}, width[k], (k == 0) ? 2 : 6);
                prev_p[k] = pk;
            end
        end
    end

    initial begin
        int t;
        logic [6:0] exp_p, exp_n;
        int exp_pend;
        rst = 1'b1; ev_a = 1'b0; force_a = 1'b0; ev_b = 1'b0; force_b = 1'b0;
        prev_p[0] = 1'b0; prev_p[1] = 1'b0; width[0] = 0; width[1] = 0;
        tick(3);
        chk("reset_p", 32'(p_a), 32'd0);
        chk("reset_n", 32'(n_a), 32'd1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_pending", 32'(pend_a), 32'd0);
        chk("reset_overflow", 32'(ovf_a), 32'd0);
        chk("reset_n_b", 32'(n_b), 32'd1);
        rst = 1'b0;
        tick(2);

        t = cyc; q_a.push_back(t + 1);
        run_a("single", 16'h0001, 6, 64'h0, 16'h0007);

        t = cyc; q_a.push_back(t + 1); q_a.push_back(t + 5); q_a.push_back(t + 9);
        run_a("burst", 16'h0007, 12, 64'h0000_1111_2210, 16'h07FF);

        t = cyc; q_a.push_back(t + 1); q_a.push_back(t + 5); q_a.push_back(t + 9);
        run_a("simul", 16'h0013, 12, 64'h0000_1111_1110, 16'h07FF);
        tick(2);

        // Force held during cycles t+1..t+3 of a pulse launched at t.
        t = cyc; q_a.push_back(t + 1);
        exp_p = 7'b0010001;
        exp_n = 7'b1100000;
        ev_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            ev_a = 1'b0;
            if (i == 1) force_a = 1'b1;
            if (i == 4) force_a = 1'b0;
            chk("force_p", 32'(p_a), 32'(exp_p[i-1]));
            chk("force_n", 32'(n_a), 32'(exp_n[i-1]));
        end
        chk("force_busy_end", 32'(busy_a), 32'd0);
        tick(2);

        // One launch plus six events during a 6-cycle pulse on a 2-bit counter.
        t = cyc;
        q_b.push_back(t + 1); q_b.push_back(t + 9); q_b.push_back(t + 17); q_b.push_back(t + 25);
        for (int i = 1; i <= 32; i++) begin
            ev_b = (i <= 7);
            tick(1);
            if (i == 7) ev_b = 1'b0;
            exp_pend = (i == 1) ? 0 : (i == 2) ? 1 : (i == 3) ? 2 : (i <= 8) ? 3 :
                       (i <= 16) ? 2 : (i <= 24) ? 1 : 0;
            chk("sat_pending", 32'(pend_b), exp_pend);
            chk("sat_overflow", 32'(ovf_b), 32'(i >= 5));
            chk("sat_busy", 32'(busy_b), 32'(i < 32));
        end
        ev_b = 1'b0;
        tick(2);

        // Reset while in the second Assert cycle with two events queued.
        t = cyc; q_a.push_back(t + 1); q_a.push_back(t + 5);
        for (int i = 0; i < 6; i++) begin
            ev_a = (i < 4);
            tick(1);
        end
        ev_a = 1'b0;
        chk("pre_reset_pending", 32'(pend_a), 32'd2);
        chk("pre_reset_p", 32'(p_a), 32'd1);
        chk("pre_reset_overflow_b", 32'(ovf_b), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("mid_reset_p", 32'(p_a), 32'd0);
        chk("mid_reset_n", 32'(n_a), 32'd1);
        chk("mid_reset_pending", 32'(pend_a), 32'd0);
        chk("mid_reset_overflow", 32'(ovf_a), 32'd0);
        chk("mid_reset_overflow_b", 32'(ovf_b), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(12);
        chk("post_reset_busy", 32'(busy_a), 32'd0);
        chk("post_reset_p", 32'(p_a), 32'd0);

        chk("rises_left_a", q_a.size(), 32'd0);
        chk("rises_left_b", q_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
